mvm_mac_ctrl: RTL and testbench

// Sequencer that turns one external 10x10->20-bit saturating MAC into a matrix-vector unit (y = M*x).

---
 rtl/mvm_mac_ctrl_if.sv | 32 +++
 rtl/mvm_mac_ctrl.sv | 162 ++++++++++++++++
 tb/tb_mvm_mac_ctrl.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mvm_mac_ctrl_if.sv
// Stream and MAC-side signal bundle for the matrix-vector MAC sequencer.
// master = controller side, slave = data source/sink and MAC side.
interface mvm_mac_ctrl_if #(
    parameter int W     = 10,
    parameter int ACC_W = 20
);
    logic                    s_valid;
    logic                    s_ready;
    logic signed [W-1:0]     s_data;
    logic                    m_valid;
    logic                    m_ready;
    logic signed [ACC_W-1:0] m_data;
    logic                    mac_clr;
    logic                    mac_valid;
    logic signed [W-1:0]     mac_a;
    logic signed [W-1:0]     mac_b;
    logic signed [ACC_W-1:0] mac_f;
    logic                    mac_valid_out;
    logic                    busy;

    modport master (
        input  s_valid, s_data, m_ready, mac_f, mac_valid_out,
        output s_ready, m_valid, m_data,
        output mac_clr, mac_valid, mac_a, mac_b, busy
    );

    modport slave (
        output s_valid, s_data, m_ready, mac_f, mac_valid_out,
        input  s_ready, m_valid, m_data,
        input  mac_clr, mac_valid, mac_a, mac_b, busy
    );
endinterface

// File: rtl/mvm_mac_ctrl.sv
// Sequencer driving one external saturating MAC to compute y = M*x.
// Loads M row-major then x, issues N MACs per row, streams y[i] out.
module mvm_mac_ctrl #(
    parameter int N     = 3,
    parameter int W     = 10,
    parameter int ACC_W = 20
) (
    input  logic          clk,
    input  logic          reset,
    mvm_mac_ctrl_if.master bus
);
    localparam logic [2:0] S_LOAD  = 3'd0;
    localparam logic [2:0] S_CLR   = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_OUT   = 3'd4;

    localparam int LDN = N * N + N;
    localparam int LW  = $clog2(LDN);
    localparam int MW  = $clog2(N * N);
    localparam int CW  = $clog2(N);
    localparam int RW  = $clog2(N + 1);

    localparam logic [LW-1:0] LD_LAST = LW'(LDN - 1);
    localparam logic [LW-1:0] LD_MAT  = LW'(N * N);
    localparam logic [CW-1:0] C_LAST  = CW'(N - 1);
    localparam logic [RW-1:0] R_FULL  = RW'(N);

    logic [2:0]              r_state;
    logic [LW-1:0]           r_ld_cnt;
    logic [CW-1:0]           r_row;
    logic [CW-1:0]           r_col;
    logic [RW-1:0]           r_res_cnt;
    logic signed [W-1:0]     r_mat [N*N];
    logic signed [W-1:0]     r_vec [N];

    logic                    r_s_ready;
    logic                    r_m_valid;
    logic signed [ACC_W-1:0] r_m_data;
    logic                    r_mac_clr;
    logic                    r_mac_valid;
    logic signed [W-1:0]     r_mac_a;
    logic signed [W-1:0]     r_mac_b;
    logic                    r_busy;

    logic                    w_s_fire;
    logic                    w_m_fire;
    logic                    w_cnt_en;
    logic [RW-1:0]           w_res_nxt;
    logic [CW-1:0]           w_col_nxt;
    logic [MW-1:0]           w_mat_idx;
    logic [CW-1:0]           w_vec_idx;

    assign w_s_fire  = (r_state == S_LOAD) && r_s_ready && bus.s_valid;
    assign w_m_fire  = r_m_valid && bus.m_ready;
    assign w_cnt_en  = bus.mac_valid_out &&
                       ((r_state == S_ISSUE) || (r_state == S_DRAIN));
    assign w_res_nxt = r_res_cnt + RW'(w_cnt_en);
    // Column whose operands are presented next cycle.
    assign w_col_nxt = (r_state == S_ISSUE) ? r_col + 1'b1 : '0;
    assign w_mat_idx = MW'(int'(r_row) * N + int'(w_col_nxt));
    assign w_vec_idx = CW'(r_ld_cnt - LD_MAT);

    always_ff @(posedge clk) begin
        if (w_s_fire) begin
            if (r_ld_cnt < LD_MAT)
                r_mat[r_ld_cnt[MW-1:0]] <= bus.s_data;
            else
                r_vec[w_vec_idx] <= bus.s_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_LOAD;
            r_ld_cnt    <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_res_cnt   <= '0;
            r_s_ready   <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
            r_mac_clr   <= 1'b0;
            r_mac_valid <= 1'b0;
            r_mac_a     <= '0;
            r_mac_b     <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_mac_clr <= 1'b0;
            case (r_state)
                S_LOAD: begin
                    if (w_s_fire) begin
                        if (r_ld_cnt == LD_LAST) begin
                            r_ld_cnt  <= '0;
                            r_row     <= '0;
                            r_s_ready <= 1'b0;
                            r_busy    <= 1'b1;
                            r_mac_clr <= 1'b1;
                            r_state   <= S_CLR;
                        end else begin
                            r_ld_cnt <= r_ld_cnt + 1'b1;
                        end
                    end
                end
                S_CLR: begin
                    r_col       <= '0;
                    r_res_cnt   <= '0;
                    r_mac_valid <= 1'b1;
                    r_mac_a     <= r_mat[w_mat_idx];
                    r_mac_b     <= r_vec[w_col_nxt];
                    r_state     <= S_ISSUE;
                end
                S_ISSUE: begin
                    r_res_cnt <= w_res_nxt;
                    if (r_col == C_LAST) begin
                        r_mac_valid <= 1'b0;
                        r_state     <= S_DRAIN;
                    end else begin
                        r_col   <= w_col_nxt;
                        r_mac_a <= r_mat[w_mat_idx];
                        r_mac_b <= r_vec[w_col_nxt];
                    end
                end
                S_DRAIN: begin
                    r_res_cnt <= w_res_nxt;
                    if (w_res_nxt == R_FULL) begin
                        r_m_data  <= bus.mac_f;
                        r_m_valid <= 1'b1;
                        r_state   <= S_OUT;
                    end
                end
                S_OUT: begin
                    if (w_m_fire) begin
                        r_m_valid <= 1'b0;
                        if (r_row == C_LAST) begin
                            r_row     <= '0;
                            r_col     <= '0;
                            r_res_cnt <= '0;
                            r_s_ready <= 1'b1;
                            r_busy    <= 1'b0;
                            r_state   <= S_LOAD;
                        end else begin
                            r_row     <= r_row + 1'b1;
                            r_mac_clr <= 1'b1;
                            r_state   <= S_CLR;
                        end
                    end
                end
                default: r_state <= S_LOAD;
            endcase
        end
    end

    assign bus.s_ready   = r_s_ready;
    assign bus.m_valid   = r_m_valid;
    assign bus.m_data    = r_m_data;
    assign bus.mac_clr   = r_mac_clr;
    assign bus.mac_valid = r_mac_valid;
    assign bus.mac_a     = r_mac_a;
    assign bus.mac_b     = r_mac_b;
    assign bus.busy      = r_busy;
endmodule

// File: tb/tb_mvm_mac_ctrl.sv
// Bench for mvm_mac_ctrl: saturating 2-cycle MAC model, matrix model,
// per-cycle output/operand checker and directed matrix tests.
module tb_mvm_mac_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   n_clr = 0;
    int   n_mv = 0;

    logic signed [9:0] mdl_m [9];
    logic signed [9:0] mdl_x [3];
    longint exp_q[$];
    longint opa_q[$];
    longint opb_q[$];
    longint got_q[$];

    mvm_mac_ctrl_if #(.W(10), .ACC_W(20)) bus ();

    mvm_mac_ctrl #(.N(3), .W(10), .ACC_W(20)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic longint sat20(input longint v);
        if (v > 524287) return 524287;
        if (v < -524288) return -524288;
        return v;
    endfunction

    logic              s1_v = 1'b0;
    logic              s1_clr = 1'b0;
    logic signed [9:0] s1_a = '0;
    logic signed [9:0] s1_b = '0;
    logic signed [19:0] acc = '0;
    logic              vout = 1'b0;

    always @(posedge clk) begin
        s1_v   <= bus.mac_valid;
        s1_clr <= bus.mac_clr;
        s1_a   <= bus.mac_a;
        s1_b   <= bus.mac_b;
        vout   <= 1'b0;
        if (s1_clr) begin
            acc <= '0;
        end else if (s1_v) begin
            acc  <= 20'(sat20(longint'(acc) +
                              longint'(s1_a) * longint'(s1_b)));
            vout <= 1'b1;
        end
    end

    assign bus.mac_f         = acc;
    assign bus.mac_valid_out = vout;

    task automatic chk(input string nm, input longint act,
                       input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     nm, act, exp, $time);
        end
    endtask

    initial begin
        longint last_a = 0;
        longint last_b = 0;
        bit     hold = 1'b0;
        longint hold_d = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                last_a = 0;
                last_b = 0;
                hold = 1'b0;
            end else begin
                if (bus.mac_clr) n_clr++;
                if (bus.mac_valid) begin
                    n_mv++;
                    if (opa_q.size() == 0) begin
                        chk("mac_extra_issue", 1, 0);
                    end else begin
                        last_a = opa_q.pop_front();
                        last_b = opb_q.pop_front();
                        chk("mac_a", bus.mac_a, last_a);
                        chk("mac_b", bus.mac_b, last_b);
                    end
                end else begin
                    chk("mac_a_hold", bus.mac_a, last_a);
                    chk("mac_b_hold", bus.mac_b, last_b);
                end
                if (hold) begin
                    chk("m_valid_hold", bus.m_valid, 1);
                    chk("m_data_hold", bus.m_data, hold_d);
                end
                if (bus.m_valid) begin
                    chk("out_quiet", bus.mac_clr | bus.mac_valid, 0);
                    if (bus.m_ready) begin
                        if (exp_q.size() == 0)
                            chk("unexpected_y", 1, 0);
                        else
                            chk("y", bus.m_data, exp_q.pop_front());
                        got_q.push_back(longint'(bus.m_data));
                    end
                end
                hold = bus.m_valid && !bus.m_ready;
                hold_d = longint'(bus.m_data);
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        bus.s_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        opa_q.delete();
        opb_q.delete();
        got_q.delete();
        @(negedge clk);
        chk("rst_s_ready", bus.s_ready, 1);
        chk("rst_m_valid", bus.m_valid, 0);
        chk("rst_m_data", bus.m_data, 0);
        chk("rst_mac_clr", bus.mac_clr, 0);
        chk("rst_mac_valid", bus.mac_valid, 0);
        chk("rst_mac_ab", {bus.mac_a, bus.mac_b}, 0);
        chk("rst_busy", bus.busy, 0);
    endtask

    task automatic load(input bit toggle);
        for (int i = 0; i < 3; i++) begin
            longint a = 0;
            for (int j = 0; j < 3; j++) begin
                a = sat20(a + longint'(mdl_m[i*3+j]) * longint'(mdl_x[j]));
                opa_q.push_back(longint'(mdl_m[i*3+j]));
                opb_q.push_back(longint'(mdl_x[j]));
            end
            exp_q.push_back(a);
        end
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data = (i < 9) ? mdl_m[i] : mdl_x[i-9];
            @(negedge clk);
            chk("s_ready_load", bus.s_ready, 1);
            @(posedge clk); #1;
            bus.s_valid = 1'b0;
            if (toggle && i < 11) begin
                @(posedge clk); #1;
            end
        end
        @(negedge clk);
        chk("clr_after_load", bus.mac_clr, 1);
        chk("s_ready_drop", bus.s_ready, 0);
        chk("busy_compute", bus.busy, 1);
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while ((exp_q.size() != 0 || bus.busy) && c < 400) begin
            @(posedge clk); #1;
            c++;
        end
        if (c >= 400) chk({nm, "_timeout"}, 1, 0);
        chk({nm, "_ops_left"}, opa_q.size(), 0);
        chk({nm, "_idle_ready"}, bus.s_ready, 1);
        chk({nm, "_idle_busy"}, bus.busy, 0);
    endtask

    task automatic chk_y(input string nm, input longint e0,
                         input longint e1, input longint e2);
        chk({nm, "_count"}, got_q.size(), 3);
        if (got_q.size() == 3) begin
            chk({nm, "_y0"}, got_q[0], e0);
            chk({nm, "_y1"}, got_q[1], e1);
            chk({nm, "_y2"}, got_q[2], e2);
        end
        got_q.delete();
    endtask

    task automatic set_x(input int a, input int b, input int c);
        mdl_x[0] = 10'(a);
        mdl_x[1] = 10'(b);
        mdl_x[2] = 10'(c);
    endtask

    initial begin
        int c;
        bus.s_valid = 1'b0;
        bus.s_data = '0;
        bus.m_ready = 1'b1;
        do_reset();

        // identity
        for (int i = 0; i < 9; i++) mdl_m[i] = (i % 4 == 0) ? 10'sd1 : 10'sd0;
        set_x(5, -7, 9);
        n_clr = 0;
        n_mv = 0;
        load(1'b0);
        wait_idle("ident");
        chk_y("ident", 5, -7, 9);
        chk("ident_clr_pulses", n_clr, 3);
        chk("ident_issue_cycles", n_mv, 9);

        // 3*511*511 exceeds the 20-bit range; the MAC clamps it
        for (int i = 0; i < 9; i++) mdl_m[i] = 10'sd511;
        set_x(511, 511, 511);
        load(1'b0);
        wait_idle("pos_sat");
        chk_y("pos_sat", 524287, 524287, 524287);

        for (int i = 0; i < 9; i++) mdl_m[i] = -10'sd512;
        set_x(511, 511, 511);
        load(1'b0);
        wait_idle("neg_sat");
        chk_y("neg_sat", -524288, -524288, -524288);

        mdl_m[0] = 10;  mdl_m[1] = -20; mdl_m[2] = 30;
        mdl_m[3] = -40; mdl_m[4] = 50;  mdl_m[5] = -60;
        mdl_m[6] = 70;  mdl_m[7] = -80; mdl_m[8] = 90;
        set_x(3, 2, 1);
        load(1'b1);
        wait_idle("toggle");
        chk_y("toggle", 20, -80, 140);

        for (int i = 0; i < 9; i++) mdl_m[i] = 10'(i + 1);
        set_x(1, -1, 2);
        load(1'b0);
        c = 0;
        while (got_q.size() < 1 && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        bus.m_ready = 1'b0;
        c = 0;
        while (!bus.m_valid && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("bp_row1_out", bus.m_valid, 1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("bp_still_valid", bus.m_valid, 1);
        chk("bp_no_extra", got_q.size(), 1);
        bus.m_ready = 1'b1;
        wait_idle("bp");
        chk_y("bp", 5, 11, 17);

        for (int i = 0; i < 9; i++) mdl_m[i] = 10'sd1;
        set_x(1, 1, 1);
        load(1'b0);
        c = 0;
        while (!(got_q.size() == 1 && bus.mac_valid) && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
        chk("abort_in_issue", bus.mac_valid, 1);
        do_reset();
        for (int i = 0; i < 9; i++) mdl_m[i] = (i % 4 == 0) ? 10'sd2 : 10'sd0;
        set_x(1, 2, 3);
        load(1'b0);
        wait_idle("reload");
        repeat (5) @(posedge clk);
        #1;
        chk_y("reload", 2, 4, 6);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
